// File: rtl/rmt_dest_demux_if.sv
// rmt_dest_demux_if: stream bundle around the destination demultiplexer.
//   s_axis_* : single input stream (tdata/tkeep/tvalid/tready/tlast/tuser/tdest)
//   m_axis_* : M_COUNT output streams packed side by side, port i in slice i
// Modports:
//   slave  : the demux itself (consumes s_axis_*, produces m_axis_*)
//   master : the environment feeding the demux and sinking its outputs
interface rmt_dest_demux_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 8,
    parameter int DEST_WIDTH = 2,
    parameter int M_COUNT    = 2
);
    logic [DATA_WIDTH-1:0]         s_axis_tdata;
    logic [KEEP_WIDTH-1:0]         s_axis_tkeep;
    logic                          s_axis_tvalid;
    logic                          s_axis_tready;
    logic                          s_axis_tlast;
    logic [USER_WIDTH-1:0]         s_axis_tuser;
    logic [DEST_WIDTH-1:0]         s_axis_tdest;

    logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata;
    logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep;
    logic [M_COUNT-1:0]            m_axis_tvalid;
    logic [M_COUNT-1:0]            m_axis_tready;
    logic [M_COUNT-1:0]            m_axis_tlast;
    logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tuser, s_axis_tdest,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tuser, s_axis_tdest,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/rmt_dest_demux.sv
// rmt_dest_demux: steers whole AXI-Stream frames from the RMT header-match
// stage to one of M_COUNT output ports chosen by tdest on the first beat.
// Frames whose tdest has no port are consumed and discarded.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   axis (slave)      : input stream s_axis_* and packed outputs m_axis_*
//   stat_frames       : per-port delivered-frame counters, port i in slice i
//   stat_drop_frames  : discarded-frame counter
//   busy              : a frame is in progress or the holding register is full
module rmt_dest_demux #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 8,
    parameter int DEST_WIDTH = 2,
    parameter int M_COUNT    = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rmt_dest_demux_if.slave              axis,
    output logic [M_COUNT*CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0]         stat_drop_frames,
    output logic                         busy
);
    localparam logic [DEST_WIDTH:0] M_COUNT_L = (DEST_WIDTH+1)'(M_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

    state_t                  state, state_n;
    logic                    vld_p1;
    logic [DEST_WIDTH-1:0]   sel_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [KEEP_WIDTH-1:0]   keep_p1;
    logic                    last_p1;
    logic [USER_WIDTH-1:0]   user_p1;
    logic [M_COUNT-1:0]      m_vld;
    logic [CNT_WIDTH-1:0]    frame_cnt [M_COUNT];
    logic [CNT_WIDTH-1:0]    drop_cnt;

    logic dest_ok, out_hs, fwd_ready, rdy, s_ready, accept, fwd_beat, load, drop_inc;

    // Input stage: routing decision and acceptance
    assign dest_ok  = ({1'b0, axis.s_axis_tdest} < M_COUNT_L);
    // m_vld is one-hot, so any handshake means the selected port took the beat.
    assign out_hs    = |(m_vld & axis.m_axis_tready);
    assign fwd_ready = !vld_p1 || out_hs;
    // Ready is forced low while reset is held, independent of state.
    assign s_ready   = rdy && rst_n;
    assign accept    = axis.s_axis_tvalid && s_ready;
    assign load      = accept && fwd_beat;
    assign axis.s_axis_tready = s_ready;

    always_comb begin
        state_n  = state;
        rdy      = 1'b0;
        fwd_beat = 1'b0;
        drop_inc = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (axis.s_axis_tvalid) begin
                    if (dest_ok) begin
                        rdy      = fwd_ready;
                        fwd_beat = 1'b1;
                        if (accept && !axis.s_axis_tlast) state_n = S_FWD;
                    end else begin
                        rdy = 1'b1;
                        if (accept) begin
                            if (axis.s_axis_tlast) drop_inc = 1'b1;
                            else                   state_n  = S_DROP;
                        end
                    end
                end
            end
            S_FWD: begin
                rdy      = fwd_ready;
                fwd_beat = 1'b1;
                if (accept && axis.s_axis_tlast) state_n = S_IDLE;
            end
            S_DROP: begin
                rdy = 1'b1;
                if (accept && axis.s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            vld_p1 <= 1'b0;
            sel_p1 <= '0;
        end else begin
            state <= state_n;
            if (load)        vld_p1 <= 1'b1;
            else if (out_hs) vld_p1 <= 1'b0;
            // sel is latched only at frame start and held for the rest of the frame.
            if (load && state == S_IDLE) sel_p1 <= axis.s_axis_tdest;
        end
    end

    // Output stage: single holding register broadcast to all ports
    always_ff @(posedge clk) begin
        if (load) begin
            data_p1 <= axis.s_axis_tdata;
            keep_p1 <= axis.s_axis_tkeep;
            last_p1 <= axis.s_axis_tlast;
            user_p1 <= axis.s_axis_tuser;
        end
    end

    for (genvar i = 0; i < M_COUNT; i++) begin : g_port
        assign m_vld[i] = vld_p1 && (sel_p1 == DEST_WIDTH'(i));
        assign axis.m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = data_p1;
        assign axis.m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = keep_p1;
        assign axis.m_axis_tuser[i*USER_WIDTH +: USER_WIDTH] = user_p1;
        assign axis.m_axis_tlast[i]                          = last_p1;
        assign stat_frames[i*CNT_WIDTH +: CNT_WIDTH]         = frame_cnt[i];
    end
    assign axis.m_axis_tvalid = m_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M_COUNT; i++) frame_cnt[i] <= '0;
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < M_COUNT; i++) begin
                if (m_vld[i] && axis.m_axis_tready[i] && last_p1)
                    frame_cnt[i] <= frame_cnt[i] + 1'b1;
            end
            if (drop_inc) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign stat_drop_frames = drop_cnt;
    assign busy             = (state != S_IDLE) || vld_p1;
endmodule

// File: tb/tb_rmt_dest_demux.sv
module tb_rmt_dest_demux;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 8;
    localparam int DSW = 2;
    localparam int MC = 2;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [MC*CW-1:0] stat_frames;
    logic [CW-1:0]    stat_drop_frames;
    logic             busy;

    rmt_dest_demux_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                        .DEST_WIDTH(DSW), .M_COUNT(MC)) bus ();

    rmt_dest_demux #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                     .DEST_WIDTH(DSW), .M_COUNT(MC), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .axis             (bus.slave),
        .stat_frames      (stat_frames),
        .stat_drop_frames (stat_drop_frames),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
        int            port;
    } beat_t;

    // Reference model: frame-level routing from the first beat's dest.
    beat_t exp_q[$];
    bit    in_frame;
    int    cur_dest;
    int    frames_exp [MC];
    int    drops_exp;

    int rdy_mode;
    int cyc;
    bit saw_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_frame = 0;
        cur_dest = 0;
        for (int i = 0; i < MC; i++) frames_exp[i] = 0;
        drops_exp = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                input logic l, input logic [UW-1:0] u, input int dst);
        beat_t b;
        if (!in_frame) cur_dest = dst;
        if (cur_dest < MC) begin
            b.d = d; b.k = k; b.l = l; b.u = u; b.port = cur_dest;
            exp_q.push_back(b);
        end
        if (l) begin
            if (cur_dest < MC) frames_exp[cur_dest]++;
            else               drops_exp++;
            in_frame = 0;
        end else begin
            in_frame = 1;
        end
    endtask

    task automatic drive_ready();
        case (rdy_mode)
            1:       bus.m_axis_tready = 2'($urandom_range(0, 3));
            2:       bus.m_axis_tready = {1'b1, (cyc % 3 == 0)};
            default: bus.m_axis_tready = '1;
        endcase
        cyc++;
    endtask

    // Presents one beat and waits for it to be accepted; optionally checks
    // the output valids one cycle after acceptance.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [UW-1:0] u, input int dst,
                             input bit chk, input logic [MC-1:0] exp_v, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
        bus.s_axis_tuser  = u;
        bus.s_axis_tdest  = DSW'(dst);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            if (!acc) saw_stall = 1;
            @(posedge clk);
            #1;
            drive_ready();
            if (acc) break;
            waits++;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
        else begin
            model_accept(d, k, l, u, dst);
            if (chk) check("vld_after_accept", 64'(bus.m_axis_tvalid), 64'(exp_v));
        end
    endtask

    task automatic idle(input int n);
        bus.s_axis_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_ready();
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        rdy_mode = 0;
        bus.s_axis_tvalid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            drive_ready();
            if (exp_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_frames0"}, 64'(stat_frames[0*CW +: CW]), 64'(frames_exp[0]));
        check({tag, "_frames1"}, 64'(stat_frames[1*CW +: CW]), 64'(frames_exp[1]));
        check({tag, "_drops"}, 64'(stat_drop_frames), 64'(drops_exp));
    endtask

    // Output monitor: every handshake must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if ($countones(bus.m_axis_tvalid) > 1)
                check("onehot_valid", 64'($countones(bus.m_axis_tvalid)), 64'd1);
            for (int i = 0; i < MC; i++) begin
                if (bus.m_axis_tvalid[i] && bus.m_axis_tready[i]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(exp_q.size() != 0), 64'd1);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("out_port", 64'(i), 64'(e.port));
                        check("out_data", 64'(bus.m_axis_tdata[i*DW +: DW]), 64'(e.d));
                        check("out_keep", 64'(bus.m_axis_tkeep[i*KW +: KW]), 64'(e.k));
                        check("out_last", 64'(bus.m_axis_tlast[i]), 64'(e.l));
                        check("out_user", 64'(bus.m_axis_tuser[i*UW +: UW]), 64'(e.u));
                    end
                end
            end
        end
    end

    initial begin
        int w;
        model_reset();
        rdy_mode = 0;
        cyc = 0;
        saw_stall = 0;
        rst_n = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '1;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = '0;
        bus.s_axis_tdest  = '0;
        bus.m_axis_tready = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check_stats("rst");
        bus.s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // 3-beat frame to port 1
        send_beat(32'hA0000001, 4'hF, 1'b0, 8'h11, 1, 1, 2'b10, w);
        check("t1_busy", 64'(busy), 64'd1);
        send_beat(32'hA0000002, 4'hF, 1'b0, 8'h12, 1, 1, 2'b10, w);
        send_beat(32'hA0000003, 4'h7, 1'b1, 8'h13, 1, 1, 2'b10, w);
        drain();
        check_stats("t1");

        // Back-to-back frames switching ports with no gap
        send_beat(32'hB0000001, 4'hF, 1'b0, 8'h21, 0, 1, 2'b01, w);
        send_beat(32'hB0000002, 4'h3, 1'b1, 8'h22, 0, 1, 2'b01, w);
        check("t2_waitA", 64'(w), 64'd0);
        send_beat(32'hB0000003, 4'h1, 1'b1, 8'h23, 1, 1, 2'b10, w);
        check("t2_waitB", 64'(w), 64'd0);
        drain();
        check_stats("t2");

        // tdest changes mid-frame are ignored
        send_beat(32'hC0000001, 4'hF, 1'b0, 8'h31, 1, 1, 2'b10, w);
        for (int i = 2; i <= 4; i++)
            send_beat(32'hC0000000 + DW'(i), 4'hF, (i == 4), 8'h30 + UW'(i), 0, 1, 2'b10, w);
        drain();
        check_stats("t3");

        // Invalid dest frame is swallowed at full rate, next frame delivered
        for (int i = 1; i <= 5; i++) begin
            send_beat(32'hD0000000 + DW'(i), 4'hF, (i == 5), 8'h40 + UW'(i), 3, 1, 2'b00, w);
            check("t4_drop_wait", 64'(w), 64'd0);
        end
        send_beat(32'hD0000010, 4'hF, 1'b1, 8'h4F, 0, 1, 2'b01, w);
        drain();
        check_stats("t4");

        // Backpressure on port 0
        rdy_mode = 2;
        cyc = 0;
        saw_stall = 0;
        for (int i = 1; i <= 8; i++)
            send_beat(32'hE0000000 + DW'(i), 4'hF, (i == 8), 8'h50 + UW'(i), 0, 0, 2'b00, w);
        check("t5_stall_seen", 64'(saw_stall), 64'd1);
        drain();
        check_stats("t5");

        // Reset in the middle of a frame
        send_beat(32'hF0000001, 4'hF, 1'b0, 8'h61, 0, 0, 2'b00, w);
        send_beat(32'hF0000002, 4'hF, 1'b0, 8'h62, 0, 0, 2'b00, w);
        rst_n = 1'b0;
        bus.s_axis_tvalid = 1'b1;
        model_reset();
        #1;
        check("midrst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("midrst_tready", 64'(bus.s_axis_tready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check_stats("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(32'hF0000003, 4'hF, 1'b1, 8'h63, 1, 1, 2'b10, w);
        drain();
        check_stats("t6");

        // Randomized frames with random gaps and random port readiness
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len, dst;
            len = $urandom_range(1, 5);
            dst = $urandom_range(0, 3);
            for (int b = 0; b < len; b++) begin
                // dest on non-first beats is random to confirm it is ignored
                send_beat(DW'($urandom), KW'($urandom), (b == len - 1), UW'($urandom),
                          (b == 0) ? dst : int'($urandom_range(0, 3)), 0, 2'b00, w);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        drain();
        check_stats("rand");
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rmt_dest_demux.md
Name: rmt_dest_demux

Overview:
- Sits directly downstream of the RMT header-match stage and consumes its AXI-Stream output plus tdest (0 = default path, 1 = function-1 path).
- Steers each frame, whole, to one of M_COUNT master ports selected by the tdest value on the frame's first beat.
- Discards frames whose tdest has no port.
- Keeps per-port frame counters and a drop counter.

Parameters:
- DATA_WIDTH, 512, stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 8, tuser width.
- DEST_WIDTH, 2, tdest width.
- M_COUNT, 2, number of output ports (1..2**DEST_WIDTH).
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tuser  in  USER_WIDTH  input sideband.
- s_axis_tdest  in  DEST_WIDTH  route select; sampled only on a frame's first beat.
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  per-port data; port i occupies slice i.
- m_axis_tkeep  out  M_COUNT*KEEP_WIDTH  per-port byte enables.
- m_axis_tvalid  out  M_COUNT  per-port valid.
- m_axis_tready  in  M_COUNT  per-port ready.
- m_axis_tlast  out  M_COUNT  per-port end of frame.
- m_axis_tuser  out  M_COUNT*USER_WIDTH  per-port sideband.
- stat_frames  out  M_COUNT*CNT_WIDTH  frames delivered per port.
- stat_drop_frames  out  CNT_WIDTH  frames discarded.
- busy  out  1  high while a frame is in progress (state not IDLE or output register valid).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; output register valid = 0.
  - All m_axis_tvalid = 0; s_axis_tready = 0 while rst_n is low.
  - Counters = 0; busy = 0.
  - Data, keep and user registers are don't-care.
- Output stage:
  - A single holding register {data, keep, last, user, sel}.
  - m_axis_tvalid[i] = out_valid && (sel == i). Only one port is valid at a time.
  - Every port's data, keep, last and user buses are driven from the holding register; only the selected port's valid is asserted.
  - Latency: 1 cycle from input handshake to output valid. Full throughput: one beat per cycle when the selected port's ready is held high.
  - Output beats are never reordered, dropped or duplicated.
- Ready and accept rules:
  - fwd_ready = !out_valid || m_axis_tready[sel].
  - Input beat accepted = s_axis_tvalid && s_axis_tready.
  - Holding register loads on an accepted forwarded beat; otherwise out_valid clears when the selected port handshakes.
  - A beat may enter while the previous beat leaves in the same cycle, with no bubble.
- State machine:
  - IDLE, first beat, valid dest: tdest < M_COUNT. Latch sel = tdest, s_axis_tready = fwd_ready, forward the beat. On accept go to FWD, or stay in IDLE if tlast.
  - IDLE, first beat, invalid dest: tdest >= M_COUNT. s_axis_tready = 1, beat discarded. On accept go to DROP, or stay in IDLE if tlast.
  - FWD: s_axis_tready = fwd_ready; s_axis_tdest is ignored and sel is held. An accepted tlast beat goes to IDLE.
  - DROP: s_axis_tready = 1 and beats are discarded. An accepted tlast beat goes to IDLE.
  - IDLE with tvalid low: s_axis_tready = 0.
- Head-of-line: a stalled port blocks the input; no bypass to other ports.
- Counters (wrap modulo 2**CNT_WIDTH, no saturation):
  - stat_frames[i] increments on an output handshake of a tlast beat on port i.
  - stat_drop_frames increments on an accepted tlast beat in DROP, or on a single-beat invalid-dest frame in IDLE.
- Reset mid-frame: everything clears immediately. The first beat after rst_n rises is treated as a frame start, and tdest is sampled there.
- Simultaneous events: a tlast handshake on the output and a new frame's first beat in the same cycle are legal. The new sel is latched and the output switches ports with no gap.

Test Plan:
- 3-beat frame, tdest=1, all readies high → port 1 valid on cycles 1-3, tlast on beat 3; port 0 never valid; stat_frames[1]=1, stat_frames[0]=0.
- Frame A (2 beats, tdest=0) back-to-back with frame B (1 beat, tdest=1) → A on port 0, B on port 1 in the next cycle with no idle cycle; stat_frames = {1,1}.
- tdest changed to 0 on beats 2-4 of a 4-beat frame that starts with tdest=1 → all 4 beats on port 1.
- M_COUNT=2, 5-beat frame with tdest=3 → s_axis_tready=1 for all 5 beats; no m_axis_tvalid; stat_drop_frames=1; next frame with tdest=0 is delivered.
- m_axis_tready[0] toggled 1,0,0,1,... during an 8-beat frame to port 0 → s_axis_tready drops while the register is full; all 8 beats are delivered in order with data intact.
- rst_n pulsed low after beat 2 of a 4-beat frame → m_axis_tvalid=0 and counters=0 immediately. The following beat, with tdest=1 and tlast=1, is delivered on port 1 as a 1-beat frame.
